// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller.
// One full-adder slice plus a carry flop is stepped across the operands LSB
// first, so a WIDTH-bit add or subtract takes WIDTH RUN cycles. Subtraction
// is a + ~b + 1: B is inverted at load and the carry flop is preset to 1.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             carry_in_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic             sum_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;
  logic             overflow_d;

  // Full-adder slice on the current LSBs; the overflow term is only
  // meaningful on the last bit, where a_q[0]/b_q[0] are the operand MSBs.
  always_comb begin
    sum_bit_d  = a_q[0] ^ b_q[0] ^ c_q;
    carry_d    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    sum_d      = {sum_bit_d, sum_q[WIDTH-1:1]};
    overflow_d = (a_q[0] == b_q[0]) && (sum_bit_d != a_q[0]);
  end

  // Sequencer FSM with datapath and registered handshake/result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= op_a_i;
            b_q     <= sub_i ? ~op_b_i : op_b_i;
            c_q     <= sub_i ? 1'b1 : carry_in_i;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= carry_d;
          sum_q <= sum_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            result_q    <= sum_d;
            carry_out_q <= carry_d;
            overflow_q  <= overflow_d;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): vector table plus sequences
// for mid-RUN start, mid-RUN reset and back-to-back operation.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         carry_in_i = 1'b0;
  logic [W-1:0] op_a_i = '0;
  logic [W-1:0] op_b_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         carry_out_o;
  logic         overflow_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] held_res  = '0;
  logic         held_cout = 1'b0;
  logic         held_ovf  = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .sub_i       (sub_i),
    .carry_in_i  (carry_in_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .carry_out_o (carry_out_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs(input string nm, input logic b, input logic d,
                             input logic [W-1:0] r, input logic co, input logic ov);
    chk({nm, ".busy"}, 32'(busy_o), 32'(b));
    chk({nm, ".done"}, 32'(done_o), 32'(d));
    chk({nm, ".result"}, 32'(result_o), 32'(r));
    chk({nm, ".carry_out"}, 32'(carry_out_o), 32'(co));
    chk({nm, ".overflow"}, 32'(overflow_o), 32'(ov));
  endtask

  // One full operation; poke=1 drives a conflicting start during RUN.
  task automatic do_op(input vec_t v, input bit poke);
    @(negedge clk_i);
    start_i = 1'b1; op_a_i = v.a; op_b_i = v.b; sub_i = v.sub; carry_in_i = v.cin;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk_outputs({v.name, ".e0"}, 1'b1, 1'b0, held_res, held_cout, held_ovf);
    for (int k = 1; k <= W; k++) begin
      if (poke && k == 3) begin
        start_i = 1'b1; op_a_i = ~v.a; op_b_i = 8'h11; sub_i = ~v.sub; carry_in_i = ~v.cin;
      end
      @(posedge clk_i); #1;
      if (poke && k == 4) start_i = 1'b0;
      if (k < W) begin
        chk({v.name, ".run_busy"}, 32'(busy_o), 32'd1);
        chk({v.name, ".run_done"}, 32'(done_o), 32'd0);
        chk({v.name, ".run_hold"}, 32'(result_o), 32'(held_res));
      end else begin
        chk_outputs({v.name, ".done"}, 1'b0, 1'b1, v.res, v.cout, v.ovf);
      end
    end
    @(posedge clk_i); #1;
    chk_outputs({v.name, ".after"}, 1'b0, 1'b0, v.res, v.cout, v.ovf);
    held_res = v.res; held_cout = v.cout; held_ovf = v.ovf;
  endtask

  vec_t vecs[10];
  vec_t v;
  int   done_at[2];
  int   cyc;

  initial begin
    vecs[0] = '{"add_5a_3c",  8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{"add_ff_00c", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{"sub_10_20",  8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{"sub_80_01",  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{"add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{"sub_00_00",  8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{"add_c8_9c",  8'hC8, 8'h9C, 1'b0, 1'b0, 8'h64, 1'b1, 1'b1};
    vecs[8] = '{"sub_05_03c", 8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[9] = '{"add_12_34c", 8'h12, 8'h34, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0};

    // Reset state, then release; first start goes in on the next edge.
    #12;
    chk_outputs("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) do_op(vecs[i], 1'b0);

    // Start pulsed mid-RUN with different operands must be ignored.
    v = '{"poke_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    do_op(v, 1'b1);

    // Asynchronous reset during the 4th RUN cycle aborts the operation.
    @(negedge clk_i);
    start_i = 1'b1; op_a_i = 8'h33; op_b_i = 8'h44; sub_i = 1'b0; carry_in_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_i); #1;
    end
    #3 rst_i = 1'b1;
    #1;
    chk_outputs("midrst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      chk("midrst.no_done", 32'(done_o), 32'd0);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    held_res = '0; held_cout = 1'b0; held_ovf = 1'b0;
    v = '{"post_rst", 8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
    do_op(v, 1'b0);

    // Back-to-back: start held through the DONE cycle.
    cyc = 0;
    done_at[0] = -1;
    done_at[1] = -1;
    @(negedge clk_i);
    start_i = 1'b1; op_a_i = 8'h10; op_b_i = 8'h20; sub_i = 1'b1; carry_in_i = 1'b0;
    @(posedge clk_i); #1;
    chk("b2b.e0_busy", 32'(busy_o), 32'd1);
    for (int k = 1; k <= 2 * W + 1; k++) begin
      @(posedge clk_i); #1;
      cyc = k;
      if (k == 4) begin
        op_a_i = 8'h7F; op_b_i = 8'h01; sub_i = 1'b0;
      end
      if (done_o === 1'b1) begin
        if (done_at[0] < 0) done_at[0] = cyc;
        else if (done_at[1] < 0) done_at[1] = cyc;
      end
      if (k == W) begin
        chk_outputs("b2b.first", 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
      end
      if (k == W + 1) begin
        chk_outputs("b2b.restart", 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
        start_i = 1'b0;
      end
      if (k == 2 * W + 1) begin
        chk_outputs("b2b.second", 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
      end
    end
    chk("b2b.first_at", 32'(done_at[0]), 32'(W));
    chk("b2b.spacing", 32'(done_at[1] - done_at[0]), 32'(W + 1));
    @(posedge clk_i); #1;
    chk("b2b.done_drop", 32'(done_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
